instr_loader: RTL and testbench

Upstream feeder for the instruction memory controller of the WASM stack CPU. Accepts a WebAssembly bytecode image as a byte stream with a valid/ready handshake, checks the 8-byte module header, and packs the body bytes into instruction-memory write words. Its outputs drive the instruction memory controller's write port: `we`, `wr_data` and `write_pointer_shift_minusone`. It signals completion to the top level and flags malformed images.

---
 rtl/instr_loader_if.sv | 29 ++
 rtl/instr_loader.sv | 159 +++++++++++++++
 tb/tb_instr_loader.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write port of the instruction loader.
// master: image source / memory side (drives bytes, accepts writes).
// slave : the loader (accepts bytes, issues writes).
//   s_byte/s_vld/s_last/s_rdy            : image byte stream, transfer on s_vld & s_rdy
//   o_we/o_wr_data/o_write_pointer_...   : memory write request, held until i_wr_rdy
//   i_wr_rdy                             : memory accepts the write
interface instr_loader_if #(
  parameter int unsigned WR_BYTES     = 4,
  parameter int unsigned LOG_WR_BYTES = 2
);
  logic [7:0]              s_byte;
  logic                    s_vld;
  logic                    s_last;
  logic                    s_rdy;
  logic                    o_we;
  logic [8*WR_BYTES-1:0]   o_wr_data;
  logic [LOG_WR_BYTES-1:0] o_write_pointer_shift_minusone;
  logic                    i_wr_rdy;

  modport master (
    output s_byte, s_vld, s_last, i_wr_rdy,
    input  s_rdy, o_we, o_wr_data, o_write_pointer_shift_minusone
  );

  modport slave (
    input  s_byte, s_vld, s_last, i_wr_rdy,
    output s_rdy, o_we, o_wr_data, o_write_pointer_shift_minusone
  );
endinterface

// File: rtl/instr_loader.sv
// Instruction loader: checks the 8-byte WebAssembly header of an incoming byte
// stream, then packs body bytes (first byte in lane 0) into instruction-memory
// write words.
//   clk, rst_n    : clock, synchronous active-low reset
//   bus (slave)   : byte stream in, memory write port out
//   o_load_done   : image fully written (sticky)
//   o_hdr_error   : header mismatch or truncated header (sticky)
//   o_body_bytes  : body bytes written to memory, saturating
module instr_loader #(
  parameter int unsigned WR_BYTES     = 4,
  parameter int unsigned LOG_WR_BYTES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_loader_if.slave       bus,
  output logic                o_load_done,
  output logic                o_hdr_error,
  output logic [15:0]         o_body_bytes
);

  localparam int unsigned DW = 8 * WR_BYTES;
  localparam int unsigned FW = LOG_WR_BYTES + 1;

  typedef enum logic [2:0] {
    ST_HDR, ST_BODY, ST_WRITE, ST_DONE, ST_ERR
  } state_t;

  state_t                  state_q;
  logic [2:0]              hdr_idx_q;
  logic [FW-1:0]           fill_q;
  logic                    last_pending_q;
  logic                    s_rdy_q;
  logic                    we_q;
  logic [DW-1:0]           data_q;
  logic [LOG_WR_BYTES-1:0] shift_q;
  logic                    done_q;
  logic                    err_q;
  logic [15:0]             body_q;
  logic [16:0]             body_sum_c;

  // Expected header: "\0asm" magic followed by version 1.
  function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
    case (idx)
      3'd1:    return 8'h61;
      3'd2:    return 8'h73;
      3'd3:    return 8'h6D;
      3'd4:    return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  // Body byte count after the current word lands, one extra bit to spot overflow.
  always_comb begin
    body_sum_c = {1'b0, body_q} + 17'(fill_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_HDR;
      hdr_idx_q      <= 3'd0;
      fill_q         <= '0;
      last_pending_q <= 1'b0;
      s_rdy_q        <= 1'b0;
      we_q           <= 1'b0;
      data_q         <= '0;
      shift_q        <= '0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      body_q         <= 16'd0;
    end else begin
      case (state_q)
        ST_HDR: begin
          s_rdy_q <= 1'b1;
          if (bus.s_vld && s_rdy_q) begin
            if (bus.s_byte != hdr_byte(hdr_idx_q)) begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end else if (hdr_idx_q == 3'd7) begin
              if (bus.s_last) begin
                // Empty body: nothing to write.
                state_q <= ST_DONE;
                done_q  <= 1'b1;
                s_rdy_q <= 1'b0;
              end else begin
                state_q <= ST_BODY;
              end
            end else if (bus.s_last) begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end else begin
              hdr_idx_q <= hdr_idx_q + 3'd1;
            end
          end
        end

        ST_BODY: begin
          if (bus.s_vld && s_rdy_q) begin
            for (int unsigned l = 0; l < WR_BYTES; l++) begin
              if (fill_q == FW'(l)) data_q[l*8 +: 8] <= bus.s_byte;
            end
            fill_q <= fill_q + FW'(1);
            if (fill_q == FW'(WR_BYTES - 1) || bus.s_last) begin
              state_q        <= ST_WRITE;
              s_rdy_q        <= 1'b0;
              we_q           <= 1'b1;
              // Old fill equals the new byte count minus one.
              shift_q        <= fill_q[LOG_WR_BYTES-1:0];
              last_pending_q <= bus.s_last;
            end
          end
        end

        ST_WRITE: begin
          if (bus.i_wr_rdy) begin
            we_q    <= 1'b0;
            fill_q  <= '0;
            data_q  <= '0;
            shift_q <= '0;
            body_q  <= body_sum_c[16] ? 16'hFFFF : body_sum_c[15:0];
            if (last_pending_q) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_BODY;
              s_rdy_q <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          s_rdy_q <= 1'b0;
          we_q    <= 1'b0;
        end

        ST_ERR: begin
          // Keep draining the upstream; bytes are dropped.
          s_rdy_q <= 1'b1;
          we_q    <= 1'b0;
        end

        default: begin
          state_q <= ST_ERR;
          err_q   <= 1'b1;
          we_q    <= 1'b0;
          s_rdy_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.s_rdy                          = s_rdy_q;
  assign bus.o_we                           = we_q;
  assign bus.o_wr_data                      = data_q;
  assign bus.o_write_pointer_shift_minusone = shift_q;
  assign o_load_done                        = done_q;
  assign o_hdr_error                        = err_q;
  assign o_body_bytes                       = body_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: expected write words are queued as body
// bytes are driven and checked when the loader's write transfers.
module tb_instr_loader;

  localparam int unsigned WR_BYTES     = 4;
  localparam int unsigned LOG_WR_BYTES = 2;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  shift;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic        o_load_done;
  logic        o_hdr_error;
  logic [15:0] o_body_bytes;

  int  n_assert;
  int  n_fail;
  int  writes;
  int  w0;
  wr_t sb[$];

  instr_loader_if #(.WR_BYTES(WR_BYTES), .LOG_WR_BYTES(LOG_WR_BYTES)) bus ();

  instr_loader #(.WR_BYTES(WR_BYTES), .LOG_WR_BYTES(LOG_WR_BYTES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .o_load_done  (o_load_done),
    .o_hdr_error  (o_hdr_error),
    .o_body_bytes (o_body_bytes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // A write transfers at the next rising edge when o_we & i_wr_rdy hold now.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && bus.o_we && bus.i_wr_rdy) begin
      writes++;
      chk("write_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wr_data", bus.o_wr_data, e.data);
        chk("wr_shift", 32'(bus.o_write_pointer_shift_minusone), 32'(e.shift));
      end
    end
  end

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.s_vld   = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_byte  = 8'h00;
    @(posedge clk); #1;
    chk("rst_s_rdy", 32'(bus.s_rdy), 32'd0);
    chk("rst_we", 32'(bus.o_we), 32'd0);
    chk("rst_data", bus.o_wr_data, 32'd0);
    chk("rst_shift", 32'(bus.o_write_pointer_shift_minusone), 32'd0);
    chk("rst_done", 32'(o_load_done), 32'd0);
    chk("rst_err", 32'(o_hdr_error), 32'd0);
    chk("rst_body", 32'(o_body_bytes), 32'd0);
    sb.delete();
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_s_rdy", 32'(bus.s_rdy), 32'd1);
  endtask

  // Present one byte and hold it until the loader takes it (bounded).
  task automatic send(input logic [7:0] b, input logic last);
    int  n;
    logic acc;
    n = 0;
    bus.s_byte = b;
    bus.s_last = last;
    bus.s_vld  = 1'b1;
    do begin
      acc = bus.s_rdy;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 64);
    chk("byte_accepted", 32'(acc), 32'd1);
    bus.s_vld  = 1'b0;
    bus.s_last = 1'b0;
  endtask

  task automatic send_hdr(input logic last_on_7);
    logic [7:0] h [8];
    h = '{8'h00, 8'h61, 8'h73, 8'h6D, 8'h01, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) send(h[i], (i == 7) ? last_on_7 : 1'b0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!o_load_done && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    chk("load_done", 32'(o_load_done), 32'd1);
  endtask

  initial begin
    logic [7:0] body [8];
    n_assert    = 0;
    n_fail      = 0;
    writes      = 0;
    bus.i_wr_rdy = 1'b1;

    // Full words.
    do_reset();
    w0 = writes;
    send_hdr(1'b0);
    chk("hdr_no_write", 32'(writes - w0), 32'd0);
    chk("hdr_no_we", 32'(bus.o_we), 32'd0);
    sb.push_back('{data: 32'h05410020, shift: 2'd3});
    sb.push_back('{data: 32'h02010B6A, shift: 2'd3});
    body = '{8'h20, 8'h00, 8'h41, 8'h05, 8'h6A, 8'h0B, 8'h01, 8'h02};
    for (int i = 0; i < 4; i++) send(body[i], 1'b0);
    chk("full_we_latency", 32'(bus.o_we), 32'd1);
    chk("full_rdy_low", 32'(bus.s_rdy), 32'd0);
    for (int i = 4; i < 8; i++) send(body[i], i == 7);
    wait_done();
    chk("full_writes", 32'(writes - w0), 32'd2);
    chk("full_body", 32'(o_body_bytes), 32'd8);
    chk("full_sb_empty", 32'(sb.size()), 32'd0);

    // Partial last word.
    do_reset();
    w0 = writes;
    send_hdr(1'b0);
    sb.push_back('{data: 32'h000B0741, shift: 2'd2});
    send(8'h41, 1'b0);
    send(8'h07, 1'b0);
    send(8'h0B, 1'b1);
    wait_done();
    chk("part_writes", 32'(writes - w0), 32'd1);
    chk("part_body", 32'(o_body_bytes), 32'd3);
    chk("part_sb_empty", 32'(sb.size()), 32'd0);

    // Back-pressure.
    do_reset();
    w0 = writes;
    bus.i_wr_rdy = 1'b0;
    send_hdr(1'b0);
    sb.push_back('{data: 32'h44332211, shift: 2'd3});
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_we", 32'(bus.o_we), 32'd1);
      chk("bp_data", bus.o_wr_data, 32'h44332211);
      chk("bp_s_rdy", 32'(bus.s_rdy), 32'd0);
      @(posedge clk); #1;
    end
    chk("bp_we_held", 32'(bus.o_we), 32'd1);
    bus.i_wr_rdy = 1'b1;
    @(posedge clk); #1;
    chk("bp_we_dropped", 32'(bus.o_we), 32'd0);
    chk("bp_s_rdy_back", 32'(bus.s_rdy), 32'd1);
    chk("bp_writes", 32'(writes - w0), 32'd1);
    sb.push_back('{data: 32'h00000055, shift: 2'd0});
    send(8'h55, 1'b1);
    wait_done();
    chk("bp_body", 32'(o_body_bytes), 32'd5);
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Header mismatch on byte 1.
    do_reset();
    w0 = writes;
    send(8'h00, 1'b0);
    chk("mm_err_before", 32'(o_hdr_error), 32'd0);
    send(8'h62, 1'b0);
    chk("mm_err", 32'(o_hdr_error), 32'd1);
    for (int i = 0; i < 10; i++) send(8'(i + 16), i == 9);
    chk("mm_drain_rdy", 32'(bus.s_rdy), 32'd1);
    chk("mm_no_write", 32'(writes - w0), 32'd0);
    chk("mm_not_done", 32'(o_load_done), 32'd0);

    // Truncated header: s_last on byte 5.
    do_reset();
    send(8'h00, 1'b0);
    send(8'h61, 1'b0);
    send(8'h73, 1'b0);
    send(8'h6D, 1'b0);
    send(8'h01, 1'b0);
    chk("tr_err_before", 32'(o_hdr_error), 32'd0);
    send(8'h00, 1'b1);
    chk("tr_err", 32'(o_hdr_error), 32'd1);

    // Empty body.
    do_reset();
    w0 = writes;
    send_hdr(1'b1);
    chk("empty_done", 32'(o_load_done), 32'd1);
    chk("empty_we", 32'(bus.o_we), 32'd0);
    chk("empty_body", 32'(o_body_bytes), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("empty_no_write", 32'(writes - w0), 32'd0);

    // Reset while a write is stalled, then a clean load.
    do_reset();
    bus.i_wr_rdy = 1'b0;
    send_hdr(1'b0);
    sb.push_back('{data: 32'h0D0C0B0A, shift: 2'd3});
    send(8'h0A, 1'b0);
    send(8'h0B, 1'b0);
    send(8'h0C, 1'b0);
    send(8'h0D, 1'b0);
    chk("ml_we_pending", 32'(bus.o_we), 32'd1);
    do_reset();
    bus.i_wr_rdy = 1'b1;
    w0 = writes;
    send_hdr(1'b0);
    sb.push_back('{data: 32'hDDCCBBAA, shift: 2'd3});
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b0);
    send(8'hDD, 1'b1);
    wait_done();
    chk("ml_writes", 32'(writes - w0), 32'd1);
    chk("ml_body", 32'(o_body_bytes), 32'd4);
    chk("ml_err", 32'(o_hdr_error), 32'd0);
    chk("ml_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
